// File: rtl/mtc2sl_rx_decoder_pkg.sv
// Shared definitions for the MTC2SL receive decoder: word layout, procflag codes and
// the mapping from procflags to the statistics class.
package mtc2sl_rx_pkg;

    // Word layout mirrors the MTC2SL entry of the L0MDT data formats header.
    localparam int unsigned MTC2SL_LEN               = 32;
    localparam int unsigned MTC2SL_MDT_PROCFLAGS_MSB = 27;
    localparam int unsigned MTC2SL_MDT_PROCFLAGS_LSB = 24;

    // Processing flag codes carried in the payload.
    localparam logic [3:0] PF_NODATA        = 4'h0;
    localparam logic [3:0] PF_PASS          = 4'h1;
    localparam logic [3:0] PF_BELOW_THR     = 4'h2;
    localparam logic [3:0] PF_SLID_MISMATCH = 4'h3;
    localparam logic [3:0] PF_NOSEG         = 4'h4;
    localparam logic [3:0] PF_ONESEG        = 4'h5;
    localparam logic [3:0] PF_MULTISEG      = 4'h6;
    localparam logic [3:0] PF_UNKNOWN       = 4'hF;

    typedef enum logic [1:0] {
        CLS_NODATA,
        CLS_PASS,
        CLS_FAIL,
        CLS_OTHER
    } mtc2sl_class_e;

    // Everything that is not an explicit pass/fail/no-data code counts as "other",
    // including reserved values.
    function automatic mtc2sl_class_e procflags_class(input logic [3:0] pf);
        case (pf)
            PF_NODATA:    return CLS_NODATA;
            PF_PASS:      return CLS_PASS;
            PF_BELOW_THR: return CLS_FAIL;
            default:      return CLS_OTHER;
        endcase
    endfunction

endpackage

// File: rtl/mtc2sl_rx_decoder_if.sv
// Candidate stream bundle: per-channel MTC2SL input words and the merged
// valid/ready output stream of the decoder.
interface mtc2sl_rx_decoder_if
    import mtc2sl_rx_pkg::*;
#(
    parameter int unsigned N_CH = 3
) ();

    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [MTC2SL_LEN-1:0] mtc_in [N_CH];
    logic [MTC2SL_LEN-2:0] out_data;
    logic [CH_W-1:0]       out_ch;
    logic [3:0]            out_procflags;
    logic                  out_valid;
    logic                  out_ready;

    // Source of words and sink of the merged stream.
    modport master (
        output mtc_in,
        output out_ready,
        input  out_data,
        input  out_ch,
        input  out_procflags,
        input  out_valid
    );

    // The decoder itself.
    modport slave (
        input  mtc_in,
        input  out_ready,
        output out_data,
        output out_ch,
        output out_procflags,
        output out_valid
    );

endinterface

// File: rtl/mtc2sl_rx_decoder_ch_fifo.sv
// Per-channel synchronous FIFO. A push while full is taken only when a pop
// happens in the same cycle, leaving occupancy unchanged.
module mtc2sl_ch_fifo #(
    parameter int unsigned WIDTH = 31,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; reset empties the FIFO.
    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/mtc2sl_rx_decoder.sv
// MTC2SL receive decoder: buffers one word per channel per cycle, merges the
// channels round-robin onto a single valid/ready stream and keeps saturating
// per-class and per-channel drop statistics.
module mtc2sl_rx_decoder
    import mtc2sl_rx_pkg::*;
#(
    parameter int unsigned N_CH       = 3,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                 clock,
    input  logic                 rst,
    mtc2sl_rx_decoder_if.slave   bus,
    input  logic                 clear_cnt,
    output logic [CNT_W-1:0]     pass_cnt,
    output logic [CNT_W-1:0]     fail_cnt,
    output logic [CNT_W-1:0]     other_cnt,
    output logic [CNT_W-1:0]     nodata_cnt,
    output logic [CNT_W-1:0]     drop_cnt [N_CH],
    output logic [N_CH-1:0]      overflow
);

    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned PL_W = MTC2SL_LEN - 1;

    logic [N_CH-1:0] push;
    logic [N_CH-1:0] pop;
    logic [N_CH-1:0] full;
    logic [N_CH-1:0] empty;
    logic [N_CH-1:0] drop;
    logic [PL_W-1:0] rd_data [N_CH];

    logic            grant_valid;
    logic [CH_W-1:0] grant_ch;
    logic [CH_W-1:0] rr_q;
    logic            load_en;
    logic            handshake;
    mtc2sl_class_e   hs_class;

    logic            out_valid_q;
    logic [PL_W-1:0] out_data_q;
    logic [CH_W-1:0] out_ch_q;
    logic [3:0]      out_procflags_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign push[c] = bus.mtc_in[c][MTC2SL_LEN-1];
        // A word is lost only when its FIFO is full and not draining this cycle.
        assign drop[c] = push[c] && full[c] && !pop[c];

        mtc2sl_ch_fifo #(
            .WIDTH (PL_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clock   (clock),
            .rst     (rst),
            .push    (push[c]),
            .pop     (pop[c]),
            .wr_data (bus.mtc_in[c][PL_W-1:0]),
            .rd_data (rd_data[c]),
            .full    (full[c]),
            .empty   (empty[c])
        );
    end

    // Round-robin search for the first non-empty FIFO starting at rr_q.
    always_comb begin
        int unsigned     sum;
        logic [CH_W-1:0] cand;
        grant_valid = 1'b0;
        grant_ch    = '0;
        sum         = 0;
        cand        = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            sum = 32'(rr_q) + i;
            if (sum >= N_CH) sum = sum - N_CH;
            cand = CH_W'(sum);
            if (!grant_valid && !empty[cand]) begin
                grant_valid = 1'b1;
                grant_ch    = cand;
            end
        end
    end

    // Output register refills when empty or being drained this cycle.
    assign load_en   = !out_valid_q || bus.out_ready;
    assign handshake = out_valid_q && bus.out_ready;
    assign hs_class  = procflags_class(out_procflags_q);

    // One-hot pop of the granted FIFO.
    always_comb begin
        pop = '0;
        if (load_en && grant_valid) pop[grant_ch] = 1'b1;
    end

    // Output register and round-robin pointer; pointer moves only on a pop.
    always_ff @(posedge clock) begin
        if (rst) begin
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
            out_ch_q        <= '0;
            out_procflags_q <= '0;
            rr_q            <= '0;
        end else if (load_en) begin
            out_valid_q <= grant_valid;
            if (grant_valid) begin
                out_data_q      <= rd_data[grant_ch];
                out_ch_q        <= grant_ch;
                out_procflags_q <=
                    rd_data[grant_ch][MTC2SL_MDT_PROCFLAGS_MSB:MTC2SL_MDT_PROCFLAGS_LSB];
                rr_q <= (grant_ch == CH_W'(N_CH - 1)) ? '0 : grant_ch + CH_W'(1);
            end
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.out_data      = out_data_q;
    assign bus.out_ch        = out_ch_q;
    assign bus.out_procflags = out_procflags_q;

    // Per-class counters, bumped on each accepted word; clear wins over increment.
    always_ff @(posedge clock) begin
        if (rst || clear_cnt) begin
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            other_cnt  <= '0;
            nodata_cnt <= '0;
        end else if (handshake) begin
            unique case (hs_class)
                CLS_PASS:   pass_cnt   <= sat_inc(pass_cnt);
                CLS_FAIL:   fail_cnt   <= sat_inc(fail_cnt);
                CLS_NODATA: nodata_cnt <= sat_inc(nodata_cnt);
                CLS_OTHER:  other_cnt  <= sat_inc(other_cnt);
            endcase
        end
    end

    // Per-channel drop counters and sticky overflow flags.
    always_ff @(posedge clock) begin
        if (rst || clear_cnt) begin
            for (int c = 0; c < N_CH; c++) drop_cnt[c] <= '0;
            overflow <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (drop[c]) begin
                    drop_cnt[c] <= sat_inc(drop_cnt[c]);
                    overflow[c] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mtc2sl_rx_decoder.sv
// Scoreboard bench for mtc2sl_rx_decoder: a queue-level model predicts the
// merged stream and statistics; a negedge monitor checks every handshake.
module tb_mtc2sl_rx_decoder;
    import mtc2sl_rx_pkg::*;

    localparam int N_CH  = 3;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam int W     = MTC2SL_LEN - 1;
    localparam int PF_HI = MTC2SL_MDT_PROCFLAGS_MSB;
    localparam int PF_LO = MTC2SL_MDT_PROCFLAGS_LSB;
    localparam int SAT   = 65535;

    typedef struct {
        int           ch;
        logic [W-1:0] data;
    } exp_t;

    logic             clock = 1'b0;
    logic             rst;
    logic             clear_cnt;
    logic [CNT_W-1:0] pass_cnt, fail_cnt, other_cnt, nodata_cnt;
    logic [CNT_W-1:0] drop_cnt [N_CH];
    logic [N_CH-1:0]  overflow;

    mtc2sl_rx_decoder_if #(.N_CH(N_CH)) bus ();

    mtc2sl_rx_decoder #(
        .N_CH       (N_CH),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .bus        (bus.slave),
        .clear_cnt  (clear_cnt),
        .pass_cnt   (pass_cnt),
        .fail_cnt   (fail_cnt),
        .other_cnt  (other_cnt),
        .nodata_cnt (nodata_cnt),
        .drop_cnt   (drop_cnt),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int hs_seen = 0;

    // Reference model state
    logic [W-1:0] mq [N_CH][$];
    bit           m_slot_valid = 0;
    logic [W-1:0] m_slot_data = '0;
    int           m_start = 0;
    int           m_pass = 0, m_fail = 0, m_other = 0, m_nodata = 0;
    int           m_drop [N_CH] = '{default: 0};
    bit           m_ovf [N_CH] = '{default: 0};
    exp_t         exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v < SAT) ? v + 1 : v;
    endfunction

    // One clock of the queue model, using the inputs currently driven.
    task automatic model_cycle();
        int popped;
        int len_before [N_CH];
        logic [3:0] pf;
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                mq[c].delete();
                m_drop[c] = 0;
                m_ovf[c]  = 0;
            end
            m_slot_valid = 0;
            m_start = 0;
            m_pass = 0; m_fail = 0; m_other = 0; m_nodata = 0;
            exp_q.delete();
            return;
        end
        popped = -1;
        for (int c = 0; c < N_CH; c++) len_before[c] = mq[c].size();
        if (m_slot_valid && bus.out_ready) begin
            pf = m_slot_data[PF_HI:PF_LO];
            if (pf == 4'd1)      m_pass   = sat(m_pass);
            else if (pf == 4'd2) m_fail   = sat(m_fail);
            else if (pf == 4'd0) m_nodata = sat(m_nodata);
            else                 m_other  = sat(m_other);
        end
        if (!m_slot_valid || bus.out_ready) begin
            m_slot_valid = 0;
            for (int k = 0; k < N_CH; k++) begin
                int c;
                c = (m_start + k) % N_CH;
                if (popped < 0 && mq[c].size() > 0) begin
                    m_slot_data  = mq[c].pop_front();
                    m_slot_valid = 1;
                    popped = c;
                    exp_q.push_back('{ch: c, data: m_slot_data});
                end
            end
            if (popped >= 0) m_start = (popped + 1) % N_CH;
        end
        for (int c = 0; c < N_CH; c++) begin
            if (bus.mtc_in[c][W]) begin
                if (len_before[c] < DEPTH || popped == c) begin
                    mq[c].push_back(bus.mtc_in[c][W-1:0]);
                end else begin
                    m_drop[c] = sat(m_drop[c]);
                    m_ovf[c]  = 1;
                end
            end
        end
        if (clear_cnt) begin
            m_pass = 0; m_fail = 0; m_other = 0; m_nodata = 0;
            for (int c = 0; c < N_CH; c++) begin
                m_drop[c] = 0;
                m_ovf[c]  = 0;
            end
        end
    endtask

    task automatic step();
        model_cycle();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [W:0] make_word(input logic [3:0] pf);
        logic [W-1:0] p;
        p = W'($urandom);
        p[PF_HI:PF_LO] = pf;
        return {1'b1, p};
    endfunction

    task automatic idle_inputs();
        for (int c = 0; c < N_CH; c++) bus.mtc_in[c] = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_pass"},   64'(pass_cnt),   64'(m_pass));
        check({tag, "_fail"},   64'(fail_cnt),   64'(m_fail));
        check({tag, "_other"},  64'(other_cnt),  64'(m_other));
        check({tag, "_nodata"}, 64'(nodata_cnt), 64'(m_nodata));
        for (int c = 0; c < N_CH; c++) begin
            check($sformatf("%s_drop%0d", tag, c), 64'(drop_cnt[c]), 64'(m_drop[c]));
            check($sformatf("%s_ovf%0d", tag, c), 64'(overflow[c]), 64'(m_ovf[c]));
        end
    endtask

    // Monitor: compare every handshake with the scoreboard, and check hold stability.
    bit           prev_stall = 0;
    logic [W-1:0] prev_data;
    logic [1:0]   prev_ch;
    logic [3:0]   prev_pf;

    always @(negedge clock) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(bus.out_valid), 64'(1));
                check("hold_data", 64'(bus.out_data), 64'(prev_data));
                check("hold_ch", 64'(bus.out_ch), 64'(prev_ch));
                check("hold_pf", 64'(bus.out_procflags), 64'(prev_pf));
            end
            if (bus.out_valid && bus.out_ready) begin
                hs_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 64'(bus.out_data), 64'(0));
                    errors += (bus.out_data == '0) ? 1 : 0;
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_data", 64'(bus.out_data), 64'(e.data));
                    check("out_ch", 64'(bus.out_ch), 64'(e.ch));
                    check("out_pf", 64'(bus.out_procflags), 64'(e.data[PF_HI:PF_LO]));
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_ch    = bus.out_ch;
            prev_pf    = bus.out_procflags;
        end
    end

    initial begin
        int hs0;
        rst = 1'b1;
        clear_cnt = 1'b0;
        bus.out_ready = 1'b0;
        idle_inputs();
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_valid", 64'(bus.out_valid), 64'(0));
        check("rst_data", 64'(bus.out_data), 64'(0));
        check("rst_ch", 64'(bus.out_ch), 64'(0));
        check("rst_pf", 64'(bus.out_procflags), 64'(0));
        check_counters("rst");

        // Single word on channel 1: visible one edge after it lands in the FIFO.
        bus.out_ready = 1'b1;
        bus.mtc_in[1] = make_word(4'd1);
        step();
        idle_inputs();
        check("t1_lat0", 64'(bus.out_valid), 64'(0));
        step();
        check("t1_lat1", 64'(bus.out_valid), 64'(1));
        check("t1_ch", 64'(bus.out_ch), 64'(1));
        repeat (3) step();
        check("t1_pass_const", 64'(pass_cnt), 64'(1));
        check_counters("t1");

        // All channels at once: ch0, ch1, ch2 in order.
        do_reset();
        bus.mtc_in[0] = make_word(4'd1);
        bus.mtc_in[1] = make_word(4'd2);
        bus.mtc_in[2] = make_word(4'd3);
        step();
        idle_inputs();
        repeat (5) step();
        check("t2_pass", 64'(pass_cnt), 64'(1));
        check("t2_fail", 64'(fail_cnt), 64'(1));
        check("t2_other", 64'(other_cnt), 64'(1));
        check_counters("t2");

        // Backpressure overflow on channel 0.
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.mtc_in[0] = make_word(4'($urandom_range(0, 15)));
            step();
        end
        idle_inputs();
        step();
        check("t3_drop0", 64'(drop_cnt[0]), 64'(1));
        check("t3_ovf0", 64'(overflow[0]), 64'(1));
        check_counters("t3a");
        hs0 = hs_seen;
        bus.out_ready = 1'b1;
        repeat (8) step();
        check("t3_emitted", 64'(hs_seen - hs0), 64'(5));
        check("t3_drained", 64'(exp_q.size()), 64'(0));

        // Random traffic against random backpressure.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < N_CH; c++) begin
                bus.mtc_in[c] = ($urandom_range(0, 1) == 1) ?
                    make_word(4'($urandom_range(0, 15))) : '0;
                if ($urandom_range(0, 7) == 0) bus.mtc_in[c][W] = 1'b0;
            end
            bus.out_ready = ($urandom_range(0, 1) == 1);
            clear_cnt = ($urandom_range(0, 63) == 0);
            step();
            if (i % 250 == 0) check_counters("t4mid");
        end
        idle_inputs();
        clear_cnt = 1'b0;
        bus.out_ready = 1'b1;
        repeat (20) step();
        check_counters("t4");
        check("t4_drained", 64'(exp_q.size()), 64'(0));

        // Saturation of pass_cnt, then clear colliding with a handshake.
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            bus.mtc_in[0] = make_word(4'd1);
            step();
        end
        idle_inputs();
        repeat (4) step();
        check("t5_fffe", 64'(pass_cnt), 64'(16'hFFFE));
        for (int i = 0; i < 3; i++) begin
            bus.mtc_in[0] = make_word(4'd1);
            step();
        end
        idle_inputs();
        repeat (4) step();
        check("t5_ffff", 64'(pass_cnt), 64'(16'hFFFF));
        check_counters("t5a");
        bus.mtc_in[0] = make_word(4'd1);
        step();
        idle_inputs();
        step();
        check("t5_pre_clear_valid", 64'(bus.out_valid), 64'(1));
        clear_cnt = 1'b1;
        step();
        clear_cnt = 1'b0;
        check("t5_cleared", 64'(pass_cnt), 64'(0));
        check_counters("t5b");

        // Reset while words are buffered and the output is held.
        bus.mtc_in[2] = make_word(4'd2);
        step();
        idle_inputs();
        repeat (3) step();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.mtc_in[0] = make_word(4'd1);
            step();
        end
        idle_inputs();
        check("t6_pre_valid", 64'(bus.out_valid), 64'(1));
        check("t6_pre_fail", 64'(fail_cnt), 64'(1));
        rst = 1'b1;
        bus.out_ready = 1'b1;
        step();
        rst = 1'b0;
        check("t6_valid", 64'(bus.out_valid), 64'(0));
        check("t6_fail", 64'(fail_cnt), 64'(0));
        check_counters("t6");
        hs0 = hs_seen;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t6_quiet", 64'(bus.out_valid), 64'(0));
        end
        check("t6_no_emit", 64'(hs_seen - hs0), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mtc2sl_rx_decoder.md
Name: mtc2sl_rx_decoder

Overview:
- Receive end of the MTC-to-Sector-Logic candidate interface. It accepts up to N_CH MTC2SL words per cycle, one per primary MTC slot.
- Each word is buffered in a per-channel FIFO. The buffered words are merged round-robin onto a single valid/ready stream, with the payload and processing flags decoded.
- It keeps saturating per-class statistics counters and per-channel drop counters for monitoring and for the SL-side emulator bench.

Parameters:
- N_CH, 3, number of MTC2SL input channels.
- FIFO_DEPTH, 4, words per channel FIFO; power of 2, ≥2.
- CNT_W, 16, width of every statistics/drop counter.

Ports:
- clock  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- mtc_in[N_CH]  in  MTC2SL_LEN  MTC2SL word per channel; bit MTC2SL_LEN-1 is the word-valid flag, remaining bits are the payload.
- clear_cnt  in  1  synchronous clear of all counters and sticky flags.
- out_data  out  MTC2SL_LEN-1  payload of the granted word, valid flag stripped.
- out_ch  out  $clog2(N_CH)  source channel index.
- out_procflags  out  4  payload[MTC2SL_MDT_PROCFLAGS_MSB:MTC2SL_MDT_PROCFLAGS_LSB].
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accept.
- pass_cnt, fail_cnt, other_cnt, nodata_cnt  out  CNT_W each  per-class accepted-word counters.
- drop_cnt[N_CH]  out  CNT_W  words dropped per channel.
- overflow[N_CH]  out  1  sticky; set on first drop.

Behaviour:
- Reset: all FIFOs empty; out_valid=0; out_data=0; out_ch=0; out_procflags=0; all counters=0; overflow=0; round-robin pointer=0.
- rst asserted mid-operation discards all buffered and held words the following edge, with no partial output.
- Write: channel c writes when mtc_in[c][MSB]=1.
  - Write is accepted if FIFO c is not full, or if FIFO c is popped in the same cycle.
  - Otherwise the word is dropped: drop_cnt[c]++ and overflow[c]<=1.
- Words with the valid flag at 0 are ignored entirely.
- Output register uses AXI-style rules: once out_valid=1, out_data, out_ch and out_procflags are held stable until out_valid&out_ready.
- The output register loads when it is empty or is being emptied this cycle (out_ready=1).
- Arbiter: round-robin over non-empty FIFOs.
  - Search starts at the channel after the last granted channel; wraps N_CH-1→0.
  - One pop per cycle maximum.
  - The pointer advances only on a pop.
- Latency: word sampled at edge k is in its FIFO after edge k; out_valid=1 after edge k+1 if that FIFO was otherwise empty and out_ready stays 1.
- Throughput: 1 word/cycle sustained output; N_CH words/cycle input burst absorbed up to FIFO_DEPTH per channel.
- Classification happens on the handshake (out_valid&out_ready), using out_procflags:
  - 1 → pass_cnt.
  - 2 → fail_cnt.
  - 0 → nodata_cnt.
  - Any other value (3,4,5,6,0xF, reserved) → other_cnt.
- Counters saturate at all-ones; no wrap-around.
- clear_cnt=1 zeros all counters and overflow flags at the edge. It takes priority over a same-cycle increment, and that increment is lost.
- clear_cnt does not affect FIFO contents or the stream.
- Simultaneous drop on several channels: each drop_cnt increments independently in the same cycle.

Decomposition:
- Shared package mtc2sl_rx_pkg:
  - procflag code constants: PASS=1, BELOW_THR=2, SLID_MISMATCH=3, NOSEG=4, ONESEG=5, MULTISEG=6, UNKNOWN=4'hF;
  - class enum {NODATA,PASS,FAIL,OTHER};
  - function mapping procflags to class.
- MTC2SL_LEN and field LSB/MSB constants come from l0mdt_dataformats_svh.
- One sub-module: mtc2sl_ch_fifo, a synchronous FIFO with parameters WIDTH and DEPTH.
  - Outputs: full, empty, rd_data.
  - Same-cycle push and pop on a full FIFO is legal; occupancy is unchanged.

Test Plan:
- Single word, channel 1, procflags=1, out_ready=1 → out_valid high 2 edges after sample, out_ch=1, pass_cnt=1, all other counters 0.
- All 3 channels valid in one cycle (procflags 1,2,3), out_ready=1 → output order ch0,ch1,ch2 on consecutive cycles; pass=1, fail=1, other=1.
- out_ready=0 and channel 0 driven valid for 6 consecutive cycles → first word held stable in the output register, 4 in the FIFO, 1 dropped; drop_cnt[0]=1, overflow[0]=1; after out_ready=1, exactly 5 words emerge in input order.
- Backpressure toggled every cycle with random out_ready against continuous traffic → no duplicate or lost words; data stable while out_valid&!out_ready.
- Preload pass_cnt to 16'hFFFE, then handshake 3 pass words → saturates at 16'hFFFF; clear_cnt with a simultaneous handshake → pass_cnt=0.
- rst asserted while 2 words are buffered and out_valid=1 → the next cycle has out_valid=0 and the counters are 0, and nothing further is emitted.
